joy_press_encoder: RTL



---
 rtl/joy_press_encoder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/joy_press_encoder.sv
// Two-player joystick answer transmitter: synchronizes and debounces 8 button pads,
// arbitrates one winning press and drives a one-cold active-low code for a fixed hold window.

module joy_press_encoder_db #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic stable_o,
  output logic press_o
);
  logic       s1_q, s2_q, stable_q, press_q;
  logic [7:0] cnt_q;

  // Counter only runs while the synchronized bit disagrees with the stable level,
  // so it tops out at DEBOUNCE_CYCLES-1 and cannot wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      press_q <= 1'b0;
      if (s2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == 8'(DEBOUNCE_CYCLES - 1)) begin
        stable_q <= ~stable_q;
        press_q  <= ~stable_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;
endmodule

module joy_press_encoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_btn_p1,
  input  logic [3:0] in_btn_p2,
  input  logic       in_ack,
  output logic [7:0] out_hex_joy,
  output logic       out_valid,
  output logic       out_busy,
  output logic [1:0] out_last_player
);
  localparam int NUM_LANES = 8;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_REL} state_t;

  // Lane l: 0..3 = P1 choice1..4, 4..7 = P2 choice1..4; lane l drives bus bit 7-l.
  logic [NUM_LANES-1:0] raw, stable, press;
  assign raw = {in_btn_p2, in_btn_p1};

  joy_press_encoder_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_LANES-1:0] (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_i    (raw),
    .stable_o (stable),
    .press_o  (press)
  );

  state_t     state_q;
  logic [7:0] hex_q, code_d;
  logic [7:0] hold_q;
  logic       valid_q, busy_q, rr_q, ack_q, win_p2_q, all_rel_q;
  logic [1:0] last_q;
  logic [1:0] p1_idx, p2_idx;
  logic       any_p1, any_p2, pick_p2;
  logic [2:0] win_lane;

  // Lowest choice wins within a player; rr_q=1 gives player 2 priority on a tie.
  always_comb begin
    p1_idx = '0;
    p2_idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (press[i])     p1_idx = 2'(i);
      if (press[4 + i]) p2_idx = 2'(i);
    end
    any_p1   = |press[3:0];
    any_p2   = |press[7:4];
    pick_p2  = any_p2 && (!any_p1 || rr_q);
    win_lane = pick_p2 ? {1'b1, p2_idx} : {1'b0, p1_idx};
    code_d   = 8'hFF;
    code_d[3'd7 - win_lane] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hex_q     <= 8'hFF;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      last_q    <= 2'd0;
      rr_q      <= 1'b0;
      ack_q     <= 1'b0;
      hold_q    <= '0;
      win_p2_q  <= 1'b0;
      all_rel_q <= 1'b0;
    end else begin
      all_rel_q <= (stable == '0);
      case (state_q)
        IDLE: begin
          if (|press) begin
            state_q  <= SEND;
            hex_q    <= code_d;
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
            hold_q   <= 8'd1;
            win_p2_q <= pick_p2;
            rr_q     <= ~rr_q;
            ack_q    <= 1'b0;
          end
        end
        SEND: begin
          if (hold_q == 8'(HOLD_CYCLES)) begin
            hex_q   <= 8'hFF;
            valid_q <= 1'b0;
            last_q  <= win_p2_q ? 2'd2 : 2'd1;
            state_q <= (ack_q | in_ack) ? WAIT_REL : WAIT_ACK;
            ack_q   <= 1'b0;
          end else begin
            hold_q <= hold_q + 8'd1;
            ack_q  <= ack_q | in_ack;
          end
        end
        WAIT_ACK: begin
          if (in_ack) state_q <= WAIT_REL;
        end
        WAIT_REL: begin
          if (all_rel_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_hex_joy     = hex_q;
  assign out_valid       = valid_q;
  assign out_busy        = busy_q;
  assign out_last_player = last_q;
endmodule
